// File: rtl/alu_acc_pkg.sv
// alu_pkg -- shared constants for the alu_acc accumulator ALU.
//   Opcode encodings, the FSM state type used by the multiplier sequencing,
//   and the bit positions of the C/Z flags inside the packed flag register.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_ADC = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int NUM_FLAGS = 2;

endpackage

// File: rtl/alu_acc_if.sv
// alu_acc_if -- operand/opcode request and accumulator/status response bus.
//   A, OP, EN        : request (master drives)
//   ACC_OUT, C, Z,
//   BUSY, DONE       : response (slave drives)
interface alu_acc_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] A;
  logic [3:0]       OP;
  logic             EN;
  logic [WIDTH-1:0] ACC_OUT;
  logic             C;
  logic             Z;
  logic             BUSY;
  logic             DONE;

  modport master (output A, OP, EN, input ACC_OUT, C, Z, BUSY, DONE);
  modport slave  (input A, OP, EN, output ACC_OUT, C, Z, BUSY, DONE);
endinterface

// File: rtl/alu_acc_mul_seq.sv
// mul_seq -- unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n     : clock, async active-low reset
//   start          : begin a product (ignored while busy)
//   multiplicand   : captured on start
//   multiplier     : captured on start
//   busy           : high for exactly WIDTH cycles after start
//   done           : high in the final iteration cycle
//   product        : 2*WIDTH result, valid while done is high
// done/product are presented during the last iteration (not a cycle later) so
// the owner can commit the result on the same edge that busy drops.
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // Partial sum including the current multiplier bit.
  assign prod_d  = mplier_q[0] ? prod_q + mcand_q : prod_q;
  assign done    = busy_q && (cnt_q == CW'(1));
  assign busy    = busy_q;
  assign product = prod_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (busy_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (done) busy_q <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, multiplicand};
      mplier_q <= multiplier;
      prod_q   <= '0;
      cnt_q    <= CW'(WIDTH);
      busy_q   <= 1'b1;
    end
  end
endmodule

// File: rtl/alu_acc.sv
// alu_acc -- accumulator ALU with C/Z flags and optional multi-cycle MUL.
//   CLK, RST_N : clock, async active-low reset
//   bus        : alu_acc_if slave (A/OP/EN in; ACC_OUT/C/Z/BUSY/DONE out)
// Single-cycle ops commit on the accepting edge and pulse DONE for the next
// cycle. Define ALU_ACC_MUL_EN to build the shift-add multiplier (opcode B,
// WIDTH busy cycles); without it opcode B is a NOP and BUSY is tied low.
module alu_acc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic   CLK,
  input  logic   RST_N,
  alu_acc_if.slave bus
);
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [NUM_FLAGS-1:0] flg_q, flg_d;
  logic                 done_q;
  logic                 upd;

  // Single-cycle datapath; upd=0 marks ops that leave ACC and flags alone.
  always_comb begin
    acc_d = acc_q;
    flg_d = flg_q;
    upd   = 1'b1;
    case (bus.OP)
      OP_LD:  acc_d = bus.A;
      OP_ADD: {flg_d[FLAG_C], acc_d} = {1'b0, acc_q} + {1'b0, bus.A};
      OP_ADC: {flg_d[FLAG_C], acc_d} = {1'b0, acc_q} + {1'b0, bus.A}
                                     + {{WIDTH{1'b0}}, flg_q[FLAG_C]};
      OP_SUB: begin
        acc_d          = acc_q - bus.A;
        flg_d[FLAG_C]  = (bus.A > acc_q);
      end
      OP_AND: begin acc_d = acc_q & bus.A; flg_d[FLAG_C] = 1'b0; end
      OP_OR:  begin acc_d = acc_q | bus.A; flg_d[FLAG_C] = 1'b0; end
      OP_XOR: begin acc_d = acc_q ^ bus.A; flg_d[FLAG_C] = 1'b0; end
      OP_NOT: begin acc_d = ~acc_q;        flg_d[FLAG_C] = 1'b0; end
      OP_SHL: {flg_d[FLAG_C], acc_d} = {acc_q, 1'b0};
      OP_SHR: {acc_d, flg_d[FLAG_C]} = {1'b0, acc_q};
      default: upd = 1'b0;  // NOP, MUL, C-F
    endcase
    if (upd) flg_d[FLAG_Z] = (acc_d == '0);
  end

`ifdef ALU_ACC_MUL_EN
  state_e             state_q;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = bus.EN && (state_q == IDLE) && (bus.OP == OP_MUL);

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk          (CLK),
    .rst_n        (RST_N),
    .start        (mul_start),
    .multiplicand (acc_q),
    .multiplier   (bus.A),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_prod)
  );

  assign bus.BUSY = mul_busy;
`else
  assign bus.BUSY = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q   <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
`ifdef ALU_ACC_MUL_EN
      state_q <= IDLE;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef ALU_ACC_MUL_EN
      if (state_q == IDLE) begin
        if (bus.EN) begin
          if (bus.OP == OP_MUL) begin
            state_q <= MUL;
          end else begin
            acc_q  <= acc_d;
            flg_q  <= flg_d;
            done_q <= 1'b1;
          end
        end
      end else if (mul_done) begin
        // EN is ignored throughout MUL; result lands as BUSY drops.
        acc_q         <= mul_prod[WIDTH-1:0];
        flg_q[FLAG_C] <= |mul_prod[2*WIDTH-1:WIDTH];
        flg_q[FLAG_Z] <= (mul_prod[WIDTH-1:0] == '0);
        done_q        <= 1'b1;
        state_q       <= IDLE;
      end
`else
      if (bus.EN) begin
        acc_q  <= acc_d;
        flg_q  <= flg_d;
        done_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.ACC_OUT = acc_q;
  assign bus.C       = flg_q[FLAG_C];
  assign bus.Z       = flg_q[FLAG_Z];
  assign bus.DONE    = done_q;
endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc -- self-checking bench for alu_acc (WIDTH=8).
//   Directed table of chained single-cycle ops, hand sequences for
//   back-to-back, MUL (when ALU_ACC_MUL_EN is defined) and reset corners,
//   then random ops against an arithmetic reference model.
module tb_alu_acc;
  localparam int W = 8;
`ifdef ALU_ACC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N;

  alu_acc_if #(.WIDTH(W)) bus();

  alu_acc #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int m_acc, m_c, m_z;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] acc;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic en);
    bus.OP = op;
    bus.A  = a;
    bus.EN = en;
  endtask

  // Reference: plain integer arithmetic on an 8-bit accumulator.
  function automatic void model(input int op, input int a);
    int s;
    case (op)
      1:  m_acc = a;
      2:  begin s = m_acc + a; m_c = (s > 255); m_acc = s % 256; end
      3:  begin m_c = (a > m_acc); m_acc = (m_acc - a + 256) % 256; end
      4:  begin m_acc = m_acc & a; m_c = 0; end
      5:  begin m_acc = m_acc | a; m_c = 0; end
      6:  begin m_acc = m_acc ^ a; m_c = 0; end
      7:  begin m_acc = 255 - m_acc; m_c = 0; end
      8:  begin m_c = m_acc / 128; m_acc = (m_acc * 2) % 256; end
      9:  begin m_c = m_acc % 2; m_acc = m_acc / 2; end
      10: begin s = m_acc + a + m_c; m_c = (s > 255); m_acc = s % 256; end
      11: begin
        if (!MUL_EN) return;
        s = m_acc * a; m_c = (s > 255); m_acc = s % 256;
      end
      default: return;
    endcase
    m_z = (m_acc == 0);
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_c = 0; m_z = 0;
  endfunction

  task automatic chk_model(input string nm);
    chk({nm, ".acc"}, bus.ACC_OUT, m_acc);
    chk({nm, ".c"}, bus.C, m_c);
    chk({nm, ".z"}, bus.Z, m_z);
  endtask

  // One accepted single-cycle op, checked against the model.
  task automatic do_op(input string nm, input logic [3:0] op, input logic [7:0] a);
    drive(op, a, 1'b1);
    tick();
    model(op, a);
    chk_model(nm);
    chk({nm, ".done"}, bus.DONE, 1);
    chk({nm, ".busy"}, bus.BUSY, 0);
    drive(4'h0, 8'h00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n, seen;
    logic [3:0] op;
    logic [7:0] a;
    logic en;

    vt[0]  = '{4'h1, 8'h7F, 8'h7F, 1'b0, 1'b0};
    vt[1]  = '{4'h2, 8'h81, 8'h00, 1'b1, 1'b1};
    vt[2]  = '{4'hA, 8'h01, 8'h02, 1'b0, 1'b0};
    vt[3]  = '{4'h1, 8'h05, 8'h05, 1'b0, 1'b0};
    vt[4]  = '{4'h3, 8'h06, 8'hFF, 1'b1, 1'b0};
    vt[5]  = '{4'h9, 8'h00, 8'h7F, 1'b1, 1'b0};
    vt[6]  = '{4'h7, 8'h00, 8'h80, 1'b0, 1'b0};
    vt[7]  = '{4'h8, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[8]  = '{4'h0, 8'h33, 8'h00, 1'b1, 1'b1};
    vt[9]  = '{4'h1, 8'hAA, 8'hAA, 1'b1, 1'b0};
    vt[10] = '{4'h4, 8'h0F, 8'h0A, 1'b0, 1'b0};
    vt[11] = '{4'h5, 8'hF0, 8'hFA, 1'b0, 1'b0};
    vt[12] = '{4'h6, 8'hFF, 8'h05, 1'b0, 1'b0};
    vt[13] = '{4'hE, 8'h12, 8'h05, 1'b0, 1'b0};
    vt[14] = '{4'h3, 8'h05, 8'h00, 1'b0, 1'b1};
    vt[15] = '{4'hA, 8'hFF, 8'hFF, 1'b0, 1'b0};

    // Reset state
    RST_N = 1'b0;
    drive(4'h0, 8'h00, 1'b0);
    #12;
    chk("reset.acc", bus.ACC_OUT, 0);
    chk("reset.c", bus.C, 0);
    chk("reset.z", bus.Z, 0);
    chk("reset.busy", bus.BUSY, 0);
    chk("reset.done", bus.DONE, 0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed table, each op followed by an idle cycle to see DONE drop.
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].op, vt[i].a, 1'b1);
      tick();
      model(vt[i].op, vt[i].a);
      chk($sformatf("tbl%0d.acc", i), bus.ACC_OUT, vt[i].acc);
      chk($sformatf("tbl%0d.c", i), bus.C, vt[i].c);
      chk($sformatf("tbl%0d.z", i), bus.Z, vt[i].z);
      chk($sformatf("tbl%0d.done", i), bus.DONE, 1);
      chk($sformatf("tbl%0d.busy", i), bus.BUSY, 0);
      drive(4'h0, 8'h00, 1'b0);
      tick();
      chk($sformatf("tbl%0d.done_drop", i), bus.DONE, 0);
    end

    // Back-to-back: second op accepted in the DONE cycle of the first.
    drive(4'h1, 8'h03, 1'b1);
    tick();
    model(1, 3);
    drive(4'h2, 8'h04, 1'b1);
    tick();
    model(2, 4);
    chk("b2b.acc", bus.ACC_OUT, 8'h07);
    chk("b2b.done", bus.DONE, 1);
    drive(4'h0, 8'h00, 1'b0);
    tick();
    chk("b2b.done_drop", bus.DONE, 0);

`ifdef ALU_ACC_MUL_EN
    // MUL 0x0C*0x0B with an LD request held during BUSY.
    do_op("mul.ld", 4'h1, 8'h0C);
    drive(4'hB, 8'h0B, 1'b1);
    tick();
    chk("mul.busy0", bus.BUSY, 1);
    chk("mul.done0", bus.DONE, 0);
    drive(4'h1, 8'h55, 1'b1);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("mul.busy%0d", k), bus.BUSY, 1);
      chk($sformatf("mul.hold%0d", k), bus.ACC_OUT, 8'h0C);
      chk($sformatf("mul.nodone%0d", k), bus.DONE, 0);
    end
    tick();
    model(11, 8'h0B);
    chk("mul.busy_end", bus.BUSY, 0);
    chk("mul.done", bus.DONE, 1);
    chk("mul.acc", bus.ACC_OUT, 8'h84);
    chk("mul.c", bus.C, 0);
    drive(4'h0, 8'h00, 1'b0);
    tick();
    chk("mul.done_drop", bus.DONE, 0);
    chk("mul.ld_ignored", bus.ACC_OUT, 8'h84);

    // MUL overflow
    do_op("ovf.ld", 4'h1, 8'h10);
    drive(4'hB, 8'h10, 1'b1);
    tick();
    drive(4'h0, 8'h00, 1'b0);
    n = 0;
    while (!bus.DONE && n < 12) begin
      tick();
      n++;
    end
    model(11, 8'h10);
    chk("ovf.latency", n, 8);
    chk("ovf.acc", bus.ACC_OUT, 8'h00);
    chk("ovf.c", bus.C, 1);
    chk("ovf.z", bus.Z, 1);
`else
    // Opcode B acts as NOP without the multiplier.
    do_op("mulnop.ld", 4'h1, 8'h0C);
    do_op("mulnop", 4'hB, 8'h0B);
`endif

    // Reset in the middle of an operation (4th MUL cycle when built).
    do_op("rst.ld", 4'h1, 8'h05);
`ifdef ALU_ACC_MUL_EN
    drive(4'hB, 8'h03, 1'b1);
    tick();
    drive(4'h0, 8'h00, 1'b0);
    tick();
    tick();
    tick();
`endif
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    chk("rst.acc", bus.ACC_OUT, 0);
    chk("rst.busy", bus.BUSY, 0);
    chk("rst.done", bus.DONE, 0);
    chk("rst.c", bus.C, 0);
    seen = 0;
    repeat (3) begin
      tick();
      if (bus.DONE || bus.BUSY) seen++;
    end
    chk("rst.quiet", seen, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    do_op("rst.first_ld", 4'h1, 8'h3C);
    chk("rst.first_acc", bus.ACC_OUT, 8'h3C);

    // Random ops against the model.
    for (int it = 0; it < 300; it++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom_range(0, 255));
      en = ($urandom_range(0, 3) != 0);
      drive(op, a, en);
      tick();
      if (en && op == 4'hB && MUL_EN) begin
        chk("rnd.mul_busy", bus.BUSY, 1);
        n = 0;
        while (bus.BUSY && n < 20) begin
          drive(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
          tick();
          n++;
        end
        model(11, a);
        chk("rnd.mul_lat", n, W);
        chk_model("rnd.mul");
        chk("rnd.mul_done", bus.DONE, 1);
      end else if (en) begin
        model(op, a);
        chk_model("rnd.op");
        chk("rnd.done", bus.DONE, 1);
        chk("rnd.busy", bus.BUSY, 0);
      end else begin
        chk_model("rnd.idle");
        chk("rnd.idle_done", bus.DONE, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_acc.md
ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the datapath width in bits, equal to the register file WIDTH.
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port A, input, WIDTH bits: operand, taken from register file OUT.
REQ-005 The module SHALL have port OP, input, 4 bits: operation code.
REQ-006 The module SHALL have port EN, input, 1 bit: start request; sampled only when BUSY=0.
REQ-007 The module SHALL have port ACC_OUT, output, WIDTH bits: accumulator, driven to register file IN.
REQ-008 The module SHALL have port C, output, 1 bit: carry/borrow/overflow flag.
REQ-009 The module SHALL have port Z, output, 1 bit: zero flag.
REQ-010 The module SHALL have port BUSY, output, 1 bit: a multi-cycle operation is in progress.
REQ-011 The module SHALL have port DONE, output, 1 bit: one-cycle pulse when an accepted operation completes.

Function
REQ-012 Opcodes SHALL be: 0 NOP, 1 LD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 SHL, 9 SHR, A ADC, B MUL. Opcodes C-F SHALL behave as NOP.
REQ-013 An operation SHALL be accepted on a rising edge with EN=1 and BUSY=0.
REQ-014 Single-cycle ops SHALL update ACC and flags on the accepting edge. DONE SHALL be high for exactly the following cycle.
REQ-015 LD SHALL set ACC<=A; ADD SHALL set ACC<=ACC+A, with C=carry-out; ADC SHALL set ACC<=ACC+A+C, with C=carry-out.
REQ-016 SUB SHALL set ACC<=ACC-A (modulo 2^WIDTH), with C=1 iff A>ACC (borrow).
REQ-017 AND/OR/XOR SHALL combine ACC with A. NOT SHALL set ACC<=~ACC. All four SHALL clear C.
REQ-018 SHL/SHR SHALL shift ACC by one bit, zero-filled. C SHALL take the bit shifted out.
REQ-019 Z SHALL equal (new ACC==0) for every op except NOP. LD SHALL leave C unchanged.
REQ-020 NOP SHALL leave ACC/C/Z unchanged and SHALL still pulse DONE.
REQ-021 The FSM SHALL have states IDLE and MUL.
- IDLE->MUL on accepted MUL.
- MUL->IDLE after exactly WIDTH iteration cycles.
REQ-022 MUL SHALL compute unsigned ACC*A by shift-add. ACC SHALL receive the low WIDTH bits. C SHALL be 1 iff any high bit is nonzero. Z SHALL be per REQ-019.
REQ-023 BUSY SHALL be high from the cycle after acceptance through the final iteration cycle, i.e. WIDTH cycles. DONE SHALL pulse in the cycle after BUSY falls.
REQ-024 EN=1 while BUSY=1 SHALL be ignored, not queued. ACC_OUT SHALL hold its pre-MUL value until completion.
REQ-025 A SHALL be captured at acceptance; later changes to A SHALL NOT affect a running MUL.
REQ-026 EN asserted in the same cycle as DONE SHALL be accepted normally (back-to-back operation).

Reset
REQ-027 While RST_N=0, the module SHALL hold ACC=0, C=0, Z=0, BUSY=0, DONE=0, FSM=IDLE, and clear all multiplier state.
REQ-028 Reset asserted mid-MUL SHALL abort the operation with no DONE. The first accept SHALL be possible on the first rising edge after RST_N rises.

Configuration
REQ-029 Macro ALU_ACC_MUL_EN SHALL control the multiplier.
- Defined: MUL, the MUL state and the multiplier SHALL exist per REQ-021..025.
- Undefined: opcode B SHALL act as NOP, BUSY SHALL be tied 0, and no multiplier logic SHALL be present.

Structure
REQ-030 Package alu_pkg SHALL hold the opcode constants, the FSM state type (IDLE, MUL) and the flag bit indices.
REQ-031 The shift-add engine SHALL be sub-module mul_seq, with ports: start, multiplicand, multiplier, busy, done, 2*WIDTH product. alu_acc SHALL instantiate it only under ALU_ACC_MUL_EN.

Verification (WIDTH=8)
REQ-032 Reset scenario: assert RST_N=0 -> ACC_OUT=0x00, C=0, Z=0, BUSY=0, DONE=0.
REQ-033 Add with carry scenario: LD 0x7F, then ADD 0x81 -> ACC_OUT=0x00, C=1, Z=1, one DONE pulse per op; then ADC 0x01 -> 0x02, C=0.
REQ-034 Subtract with borrow scenario: LD 0x05, then SUB 0x06 -> ACC_OUT=0xFF, C=1, Z=0; then SHR -> 0x7F, C=1.
REQ-035 Multiply scenario: LD 0x0C, then MUL 0x0B; during BUSY drive EN=1 with OP=LD, A=0x55 -> BUSY high 8 cycles, LD ignored, ACC_OUT=0x84, C=0, one DONE pulse.
REQ-036 Multiply overflow scenario: LD 0x10, then MUL 0x10 -> ACC_OUT=0x00, C=1, Z=1.
REQ-037 Reset mid-multiply scenario: assert RST_N=0 at the 4th MUL cycle -> immediate ACC_OUT=0, BUSY=0, no DONE; LD 0x3C accepted on the first edge after release.
